// File: rtl/cei_mochila_pkg.sv
// Mochila-wide constants for the external-slave guard and its FSM state encoding.
package cei_mochila_pkg;

  localparam int unsigned EXT_TIMEOUT_CYCLES = 1024;
  localparam logic [31:0] EXT_ERR_RDATA      = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT_R = 2'd2,
    ST_RESP   = 2'd3
  } ext_guard_state_e;

endpackage

// File: rtl/obi_pkg.sv
// OBI request/response bundles shared by the bus_system ports and the external slave.
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/mochila_ext_slave_guard.sv
// Watchdog between the bus_system external-slave port and the off-chip slave: one
// transaction in flight, error response on timeout, late responses counted and dropped.
module mochila_ext_slave_guard
  import obi_pkg::*;
  import cei_mochila_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = EXT_TIMEOUT_CYCLES,
  parameter logic [31:0] ERR_RDATA      = EXT_ERR_RDATA
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  obi_req_t   bus_req_i,
  output obi_resp_t  bus_resp_o,
  output obi_req_t   ext_req_o,
  input  obi_resp_t  ext_resp_i,
  input  logic       timeout_clr_i,
  output logic       timeout_o,
  output logic [7:0] timeout_cnt_o,
  output logic [7:0] stale_cnt_o
);

  // One spare bit: a grant on the last allowed cycle lets the count step past the limit once.
  localparam int unsigned      CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  ext_guard_state_e state_q, state_d;
  obi_req_t         cap_q, cap_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             limit_hit, timeout_fire, stale_evt;

  assign limit_hit = (tmo_cnt_q >= LIMIT);
  assign stale_evt = ext_resp_i.rvalid && (state_q != ST_WAIT_R);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    cap_d        = cap_q;
    rdata_d      = rdata_q;
    tmo_cnt_d    = tmo_cnt_q;
    timeout_fire = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus_req_i.req) begin
          cap_d     = bus_req_i;
          tmo_cnt_d = '0;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (ext_resp_i.gnt) begin
          state_d = ST_WAIT_R;
        end else if (limit_hit) begin
          timeout_fire = 1'b1;
          rdata_d      = ERR_RDATA;
          state_d      = ST_RESP;
        end
      end
      ST_WAIT_R: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (ext_resp_i.rvalid) begin
          rdata_d = ext_resp_i.rdata;
          state_d = ST_RESP;
        end else if (limit_hit) begin
          timeout_fire = 1'b1;
          rdata_d      = ERR_RDATA;
          state_d      = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      cap_q         <= '0;
      rdata_q       <= '0;
      tmo_cnt_q     <= '0;
      timeout_o     <= 1'b0;
      timeout_cnt_o <= '0;
      stale_cnt_o   <= '0;
    end else begin
      state_q   <= state_d;
      cap_q     <= cap_d;
      rdata_q   <= rdata_d;
      tmo_cnt_q <= tmo_cnt_d;
      // A timeout in the same cycle as a clear keeps the flag set.
      if (timeout_fire) begin
        timeout_o <= 1'b1;
      end else if (timeout_clr_i) begin
        timeout_o <= 1'b0;
      end
      if (timeout_fire && (timeout_cnt_o != 8'hFF)) begin
        timeout_cnt_o <= timeout_cnt_o + 8'd1;
      end
      if (stale_evt && (stale_cnt_o != 8'hFF)) begin
        stale_cnt_o <= stale_cnt_o + 8'd1;
      end
    end
  end

  always_comb begin
    bus_resp_o     = '0;
    bus_resp_o.gnt = (state_q == ST_IDLE) && bus_req_i.req;
    if (state_q == ST_RESP) begin
      bus_resp_o.rvalid = 1'b1;
      bus_resp_o.rdata  = rdata_q;
    end
    ext_req_o = '0;
    if (state_q == ST_ISSUE) begin
      ext_req_o = cap_q;
    end
  end

endmodule

// File: tb/tb_mochila_ext_slave_guard.sv
// Self-checking bench for mochila_ext_slave_guard: transaction timing predicted arithmetically.
module tb_mochila_ext_slave_guard;
  import obi_pkg::*;

  localparam int          TO  = 16;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  obi_req_t   bus_req = '0;
  obi_resp_t  bus_resp;
  obi_req_t   ext_req;
  obi_resp_t  ext_resp = '0;
  logic       tclr = 1'b0;
  logic       tflag;
  logic [7:0] tcnt, scnt;

  int n_checks = 0;
  int n_fail   = 0;
  int m_tflag  = 0;
  int m_tcnt   = 0;
  int m_scnt   = 0;

  always #5 clk = ~clk;

  mochila_ext_slave_guard #(.TIMEOUT_CYCLES(TO), .ERR_RDATA(ERR)) dut (
    .clk_i(clk), .rst_i(rst), .bus_req_i(bus_req), .bus_resp_o(bus_resp),
    .ext_req_o(ext_req), .ext_resp_i(ext_resp), .timeout_clr_i(tclr),
    .timeout_o(tflag), .timeout_cnt_o(tcnt), .stale_cnt_o(scnt)
  );

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_status();
    check("timeout_o", 96'(tflag), 96'(m_tflag));
    check("timeout_cnt", 96'(tcnt), 96'(m_tcnt));
    check("stale_cnt", 96'(scnt), 96'(m_scnt));
  endtask

  // Cycle 0 is the cycle the bus request is granted. The watchdog count equals c-1 in cycle c.
  // g: cycles of ISSUE before ext gnt (>= TO means never); r: cycles in WAIT_R before rvalid.
  task automatic run_txn(input bit we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rd, input int g,
                         input int r, input bit late, input bit stale0, input bit hold,
                         input int clr_c);
    bit granted, real_done, rv_now;
    int v, thr, rv_c, resp_c, fire_c, issue_last, end_c;
    obi_req_t exp_ext;
    logic [31:0] exp_rd;
    granted = (g <= TO - 1);
    rv_c = -1;
    fire_c = -1;
    real_done = 1'b0;
    if (granted) begin
      v    = g + 1 + r;
      thr  = (g + 1 > TO - 1) ? g + 1 : TO - 1;
      rv_c = 1 + v;
      real_done = (v <= thr);
      if (real_done) resp_c = rv_c + 1;
      else begin
        fire_c = 1 + thr;
        resp_c = fire_c + 1;
      end
      issue_last = 1 + g;
    end else begin
      fire_c     = TO;
      resp_c     = TO + 1;
      issue_last = TO;
      if (late) rv_c = fire_c + 3;
    end
    end_c = resp_c;
    if (rv_c > end_c) end_c = rv_c;
    if (clr_c > end_c) end_c = clr_c;

    for (int c = 0; c <= end_c; c++) begin
      @(negedge clk);
      if (c == 0) bus_req = '{req: 1'b1, we: we, be: be, addr: addr, wdata: wdata};
      else if (hold && c <= resp_c)
        bus_req = '{req: 1'b1, we: 1'($urandom), be: 4'($urandom), addr: $urandom, wdata: $urandom};
      else bus_req = '0;
      rv_now = (c == rv_c) || (c == 0 && stale0);
      ext_resp.gnt    = granted && (c == 1 + g);
      ext_resp.rvalid = rv_now;
      ext_resp.rdata  = !rv_now ? 32'h0 : (c == rv_c) ? rd : $urandom;
      tclr = (c == clr_c);
      #1;
      check("bus_gnt", 96'(bus_resp.gnt), 96'(c == 0));
      check("bus_rvalid", 96'(bus_resp.rvalid), 96'(c == resp_c));
      exp_rd = (c != resp_c) ? 32'h0 : real_done ? rd : ERR;
      check("bus_rdata", 96'(bus_resp.rdata), 96'(exp_rd));
      exp_ext = '0;
      if (c >= 1 && c <= issue_last)
        exp_ext = '{req: 1'b1, we: we, be: be, addr: addr, wdata: wdata};
      check("ext_req", 96'(ext_req), 96'(exp_ext));
      check_status();
      // Reference update for the rising edge that ends cycle c.
      if (c == fire_c) begin
        m_tflag = 1;
        if (m_tcnt < 255) m_tcnt++;
      end else if (c == clr_c) m_tflag = 0;
      if (rv_now && !(c == rv_c && real_done) && m_scnt < 255) m_scnt++;
    end
    @(negedge clk);
    bus_req = '0;
    ext_resp = '0;
    tclr = 1'b0;
  endtask

  task automatic reset_mid_txn();
    @(negedge clk);
    bus_req = '{req: 1'b1, we: 1'b0, be: 4'hF, addr: 32'h2000_0040, wdata: 32'h0};
    @(negedge clk);
    bus_req = '0;
    ext_resp.gnt = 1'b1;
    @(negedge clk);
    ext_resp.gnt = 1'b0;
    #3 rst = 1'b1;
    #1;
    check("rst_bus_resp", 96'(bus_resp), 96'(0));
    check("rst_ext_req", 96'(ext_req), 96'(0));
    m_tflag = 0;
    m_tcnt  = 0;
    m_scnt  = 0;
    check_status();
    @(negedge clk);
    rst = 1'b0;
    ext_resp = '{gnt: 1'b0, rvalid: 1'b1, rdata: 32'hCAFE_0001};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      ext_resp = '0;
      #1;
      check("post_rst_rvalid", 96'(bus_resp.rvalid), 96'(0));
    end
    m_scnt = 1;
    check_status();
  endtask

  initial begin
    #1;
    check("reset_bus_resp", 96'(bus_resp), 96'(0));
    check("reset_ext_req", 96'(ext_req), 96'(0));
    check_status();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_txn(1'b0, 4'hF, 32'h2000_0000, 32'h0, 32'h1234_5678, 0, 0, 1'b0, 1'b0, 1'b1, -1);
    run_txn(1'b1, 4'h3, 32'h2000_0104, 32'hA5A5_0F0F, 32'h0BAD_F00D, 2, 3, 1'b0, 1'b0, 1'b0, -1);
    run_txn(1'b0, 4'hF, 32'h2000_0008, 32'h0, 32'h7777_1111, 0, TO - 2, 1'b0, 1'b0, 1'b0, -1);
    run_txn(1'b0, 4'hF, 32'h2000_000C, 32'h0, 32'h5555_AAAA, TO - 1, 0, 1'b0, 1'b0, 1'b0, -1);
    run_txn(1'b0, 4'hF, 32'h2000_0010, 32'h0, 32'h0, 99, 0, 1'b0, 1'b0, 1'b0, -1);
    run_txn(1'b0, 4'hF, 32'h2000_0014, 32'h0, 32'h1111_2222, 99, 0, 1'b1, 1'b0, 1'b0, TO + 6);
    run_txn(1'b1, 4'h1, 32'h2000_0018, 32'h1, 32'h0, 99, 0, 1'b0, 1'b1, 1'b0, TO);
    run_txn(1'b0, 4'hF, 32'h2000_001C, 32'h0, 32'h3333_4444, 5, 20, 1'b0, 1'b0, 1'b1, -1);

    for (int i = 0; i < 60; i++) begin
      run_txn(1'($urandom), 4'($urandom), $urandom, $urandom, $urandom,
              ($urandom_range(0, 3) == 0) ? $urandom_range(0, 19) : $urandom_range(0, 4),
              $urandom_range(0, 16), 1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom),
              ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : -1);
    end

    reset_mid_txn();
    run_txn(1'b0, 4'hF, 32'h2000_0000, 32'h0, 32'h1234_5678, 0, 0, 1'b0, 1'b0, 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
